// File: rtl/sr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sr_pkg                                                      |
// | Brief  : Shared constants for the SR flag bank (modes, filter width) |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package sr_pkg;

  // Conflict behaviour when the qualified pair is set=1, reset=1
  typedef enum logic [1:0] {
    RESET_DOM = 2'd0,
    SET_DOM   = 2'd1,
    HOLD      = 2'd2,
    TOGGLE    = 2'd3
  } sr_mode_e;

  localparam int unsigned CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/sr_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sr_cell                                                     |
// | Brief  : One filtered SR channel with edge pulses and conflict flag  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module sr_cell
  import sr_pkg::*;
#(
  parameter int unsigned FILTER   = 3,
  parameter int unsigned MODE     = 0,
  parameter logic        INIT_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_set,
  input  logic i_reset,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_conflict
);

  localparam logic [CNT_W-1:0] c_filter = CNT_W'(FILTER);
  localparam sr_mode_e         c_mode   = sr_mode_e'(MODE[1:0]);

  logic [1:0]       w_raw;
  logic [1:0]       r_pair;
  logic [1:0]       r_qual;
  logic [CNT_W-1:0] r_cnt;
  logic             r_qnew;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;
  logic             r_conflict;
  logic             w_qual_hit;
  logic             w_q_next;

  assign w_raw      = {i_set, i_reset};
  assign w_qual_hit = (r_cnt == c_filter);

  // Level semantics: the qualified pair is re-applied every cycle
  always_comb begin
    w_q_next = r_q;
    case (r_qual)
      2'b10: w_q_next = 1'b1;
      2'b01: w_q_next = 1'b0;
      2'b11: begin
        case (c_mode)
          RESET_DOM: w_q_next = 1'b0;
          SET_DOM:   w_q_next = 1'b1;
          HOLD:      w_q_next = r_q;
          TOGGLE:    w_q_next = r_qnew ? ~r_q : r_q;
          default:   w_q_next = r_q;
        endcase
      end
      default: w_q_next = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair     <= 2'b00;
      r_qual     <= 2'b00;
      r_cnt      <= '0;
      r_qnew     <= 1'b0;
      r_q        <= INIT_BIT;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_conflict <= 1'b0;
    end else if (i_clear) begin
      r_pair     <= 2'b00;
      r_qual     <= 2'b00;
      r_cnt      <= '0;
      r_qnew     <= 1'b0;
      r_q        <= INIT_BIT;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_pair <= w_raw;
      if (w_raw != r_pair) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt < c_filter) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // r_qnew marks the first cycle a differing pair becomes qualified
      r_qnew <= w_qual_hit && (r_pair != r_qual);
      if (w_qual_hit) begin
        r_qual     <= r_pair;
        r_conflict <= &r_pair;
      end
      r_q    <= w_q_next;
      r_rise <= ~r_q & w_q_next;
      r_fall <= r_q & ~w_q_next;
    end
  end

  assign o_q        = r_q;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_conflict = r_conflict;

endmodule
`default_nettype wire

// File: rtl/sr_flag_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sr_flag_bank                                                |
// | Brief  : Bank of WIDTH independent input-filtered SR flags           |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module sr_flag_bank
  import sr_pkg::*;
#(
  parameter int unsigned      WIDTH  = 4,
  parameter int unsigned      FILTER = 3,
  parameter int unsigned      MODE   = 0,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic             INclk,
  input  logic             INrstN,
  input  logic             INclear,
  input  logic [WIDTH-1:0] INset,
  input  logic [WIDTH-1:0] INreset,
  output logic [WIDTH-1:0] OUTq,
  output logic [WIDTH-1:0] OUTqnot,
  output logic [WIDTH-1:0] OUTrise,
  output logic [WIDTH-1:0] OUTfall,
  output logic [WIDTH-1:0] OUTconflict
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .FILTER   (FILTER),
      .MODE     (MODE),
      .INIT_BIT (INIT[i])
    ) u_cell (
      .clk        (INclk),
      .rst_n      (INrstN),
      .i_clear    (INclear),
      .i_set      (INset[i]),
      .i_reset    (INreset[i]),
      .o_q        (OUTq[i]),
      .o_rise     (OUTrise[i]),
      .o_fall     (OUTfall[i]),
      .o_conflict (OUTconflict[i])
    );
  end

  assign OUTqnot = ~OUTq;

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_sr_flag_bank                                             |
// | Brief  : Self-checking bench: four MODE variants plus INIT=1010      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_sr_flag_bank;

  localparam int W = 4;
  localparam int F = 3;
  localparam int N = 5;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr   = 1'b0;
  logic [W-1:0] s     = '0;
  logic [W-1:0] r     = '0;

  logic [W-1:0] oq [N];
  logic [W-1:0] oqn[N];
  logic [W-1:0] ori[N];
  logic [W-1:0] ofa[N];
  logic [W-1:0] oco[N];

  int checks = 0;
  int errors = 0;

  // Reference state: history of raw samples since last reset/clear
  logic [2*W-1:0] hist[$];
  logic [W-1:0]   m_q [N];
  logic [W-1:0]   m_ri[N];
  logic [W-1:0]   m_fa[N];
  logic [W-1:0]   m_co[N];
  logic [1:0]     m_qual [N][W];
  logic           m_fresh[N][W];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    sr_flag_bank #(
      .WIDTH  (W),
      .FILTER (F),
      .MODE   ((i < 4) ? i : 0),
      .INIT   ((i == 4) ? 4'b1010 : 4'b0000)
    ) u_dut (
      .INclk       (clk),
      .INrstN      (rst_n),
      .INclear     (clr),
      .INset       (s),
      .INreset     (r),
      .OUTq        (oq[i]),
      .OUTqnot     (oqn[i]),
      .OUTrise     (ori[i]),
      .OUTfall     (ofa[i]),
      .OUTconflict (oco[i])
    );
  end

  function automatic logic [W-1:0] init_of(int j);
    return (j == 4) ? 4'b1010 : 4'b0000;
  endfunction

  function automatic int mode_of(int j);
    return (j < 4) ? j : 0;
  endfunction

  function automatic logic [1:0] pair_of(logic [2*W-1:0] v, int c);
    return {v[W+c], v[c]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_q[j]  = init_of(j);
      m_ri[j] = '0;
      m_fa[j] = '0;
      m_co[j] = '0;
      for (int c = 0; c < W; c++) begin
        m_qual[j][c]  = 2'b00;
        m_fresh[j][c] = 1'b0;
      end
    end
    hist.delete();
  endtask

  // One rising edge of the specification's behaviour with current inputs
  task automatic model_edge();
    logic [1:0] cand[W];
    bit         stab[W];
    logic       qn;
    logic [1:0] nq;
    for (int c = 0; c < W; c++) begin
      stab[c] = (hist.size() >= F);
      cand[c] = 2'b00;
      if (stab[c]) begin
        cand[c] = pair_of(hist[hist.size()-1], c);
        for (int k = 1; k <= F; k++)
          if (pair_of(hist[hist.size()-k], c) != cand[c]) stab[c] = 0;
      end
    end
    if (clr) begin
      model_reset();
      return;
    end
    for (int j = 0; j < N; j++) begin
      for (int c = 0; c < W; c++) begin
        qn = m_q[j][c];
        case (m_qual[j][c])
          2'b10: qn = 1'b1;
          2'b01: qn = 1'b0;
          2'b11: begin
            case (mode_of(j))
              0:       qn = 1'b0;
              1:       qn = 1'b1;
              2:       qn = m_q[j][c];
              default: qn = m_fresh[j][c] ? ~m_q[j][c] : m_q[j][c];
            endcase
          end
          default: qn = m_q[j][c];
        endcase
        nq = stab[c] ? cand[c] : m_qual[j][c];
        m_ri[j][c]    = ~m_q[j][c] & qn;
        m_fa[j][c]    = m_q[j][c] & ~qn;
        m_fresh[j][c] = (nq != m_qual[j][c]);
        m_qual[j][c]  = nq;
        m_co[j][c]    = &nq;
        m_q[j][c]     = qn;
      end
    end
    hist.push_back({s, r});
    while (hist.size() > F) void'(hist.pop_front());
  endtask

  task automatic compare_all();
    for (int j = 0; j < N; j++)
      check($sformatf("inst%0d", j),
            32'({oq[j], oqn[j], ori[j], ofa[j], oco[j]}),
            32'({m_q[j], ~m_q[j], m_ri[j], m_fa[j], m_co[j]}));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    check("rst_qnot", 32'(oqn[0]), 32'hF);
    rst_n = 1'b1;

    // Single channel set: visible five edges after first sample
    s = 4'b0001;
    step(4);
    check("set_early", 32'(oq[0]), 32'h0);
    step(1);
    check("set_q", 32'(oq[0]), 32'h1);
    check("set_rise", 32'(ori[0]), 32'h1);
    check("set_qnot", 32'(oqn[0]), 32'hE);
    step(1);
    check("rise_once", 32'(ori[0]), 32'h0);

    // Short glitch is filtered out
    s = 4'b0010;
    step(2);
    s = 4'b0000;
    step(5);
    check("glitch_q", 32'(oq[0]), 32'h1);

    // Conflict on channel 0 in each mode
    s = 4'b0001;
    r = 4'b0001;
    step(8);
    check("m0_q", 32'(oq[0][0]), 32'h0);
    check("m1_q", 32'(oq[1][0]), 32'h1);
    check("m2_q", 32'(oq[2][0]), 32'h1);
    check("m3_q", 32'(oq[3][0]), 32'h0);
    for (int j = 0; j < 4; j++)
      check($sformatf("conf%0d", j), 32'(oco[j][0]), 32'h1);

    // Clear takes priority, then fresh qualification is needed
    s = 4'b1111;
    r = 4'b0000;
    step(8);
    check("all_set", 32'(oq[0]), 32'hF);
    clr = 1'b1;
    r   = 4'b0101;
    step(1);
    check("clr_q", 32'(oq[0]), 32'h0);
    check("clr_nofall", 32'(ofa[0]), 32'h0);
    clr = 1'b0;
    s   = 4'b1010;
    step(4);
    check("clr_requal", 32'(oq[0]), 32'h0);
    step(1);
    check("clr_after", 32'(oq[0]), 32'hA);

    // Async reset mid-filter discards the partial count
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    s   = 4'b0001;
    r   = 4'b0000;
    step(2);
    async_reset();
    check("arst_init", 32'(oq[4]), 32'hA);
    step(4);
    check("arst_hold", 32'(oq[0]), 32'h0);
    step(1);
    check("arst_q", 32'(oq[0]), 32'h1);
    check("arst_q4", 32'(oq[4]), 32'hB);

    // Simultaneous set on ch1 and reset on ch2
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    s   = 4'b0100;
    step(6);
    s = 4'b0010;
    r = 4'b0100;
    step(4);
    check("sim_pre", 32'(ori[0]), 32'h0);
    step(1);
    check("sim_q", 32'(oq[0]), 32'h2);
    check("sim_rise", 32'(ori[0]), 32'h2);
    check("sim_fall", 32'(ofa[0]), 32'h4);

    // Randomized traffic with occasional clear and async reset
    r = 4'b0000;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(2) == 0) begin
        s = 4'($urandom);
        r = 4'($urandom);
      end
      clr = ($urandom_range(39) == 0);
      if ($urandom_range(59) == 0) async_reset();
      step(1);
    end
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
